// File: rtl/rr_mux_2x1.sv
// Two-channel round-robin valid/ready stream multiplexer with a single
// registered output slot that can drain and refill in the same cycle.
module rr_mux_2x1 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sel
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_CH0  = 2'b01,
      GNT_CH1  = 2'b10
   } grant_e;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sel_q, out_sel_d;
   logic             last_q, last_d;

   logic             load;
   grant_e           grant;

   assign load = !out_valid_q || out_ready;

   // Ties go to the channel that did not win the previous accepted transfer.
   always_comb begin
      grant = GNT_NONE;
      if (in0_valid && in1_valid) begin
         grant = last_q ? GNT_CH0 : GNT_CH1;
      end else if (in0_valid) begin
         grant = GNT_CH0;
      end else if (in1_valid) begin
         grant = GNT_CH1;
      end
   end

   // Readies are masked by rst_n so nothing is handshaken while held in reset.
   always_comb begin
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      if (rst_n && load) begin
         in0_ready = (grant == GNT_CH0) && in0_valid;
         in1_ready = (grant == GNT_CH1) && in1_valid;
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
      last_d      = last_q;
      if (load) begin
         case (grant)
            GNT_CH0: begin
               out_data_d  = in0_data;
               out_sel_d   = 1'b0;
               out_valid_d = 1'b1;
               last_d      = 1'b0;
            end
            GNT_CH1: begin
               out_data_d  = in1_data;
               out_sel_d   = 1'b1;
               out_valid_d = 1'b1;
               last_d      = 1'b1;
            end
            default: begin
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sel_q   <= 1'b0;
         last_q      <= 1'b1;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
         last_q      <= last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;

endmodule
